// File: rtl/tk_sched_pkg.sv
// Shared types and sizing for the ThreadKraken barrel-thread scheduler.
// lowest_set() gives the index of the least significant set bit, or 0 when the vector is empty.
package tk_sched_pkg;

  localparam int NUM_TRD = 8;
  localparam int TRD_W   = 3;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    RUN   = 2'd1,
    SLEEP = 2'd2,
    WAIT  = 2'd3
  } trd_state_t;

  function automatic logic [TRD_W-1:0] lowest_set(input logic [NUM_TRD-1:0] v);
    logic [TRD_W-1:0] idx;
    idx = '0;
    for (int i = NUM_TRD - 1; i >= 0; i--) begin
      if (v[i]) idx = TRD_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/trd_sched_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping. Purely combinational.
// Never stalls; gnt_vld is low only when no thread is requesting.
module rr_pick
  import tk_sched_pkg::*;
(
  input  logic [NUM_TRD-1:0] req,
  input  logic [TRD_W-1:0]   ptr,
  output logic [TRD_W-1:0]   gnt_id,
  output logic               gnt_vld
);

  logic [TRD_W:0]       shamt;
  logic [2*NUM_TRD-1:0] msk;

  // Duplicating req and masking everything up to ptr in the low copy turns the
  // wrap-around search into a plain lowest-set-bit search over the doubled vector.
  always_comb begin
    shamt   = {1'b0, ptr} + (TRD_W+1)'(1);
    msk     = {req, req} & ({(2*NUM_TRD){1'b1}} << shamt);
    gnt_id  = '0;
    for (int i = 2*NUM_TRD - 1; i >= 0; i--) begin
      if (msk[i]) gnt_id = TRD_W'(i);
    end
    gnt_vld = |req;
  end

endmodule

// File: rtl/trd_sched.sv
// Barrel-thread scheduler: per-thread lifecycle FSMs, spawn allocation and round-robin fetch issue.
// Issue is registered (1 cycle); stall holds the issue slot while thread FSMs keep updating.
module trd_sched
  import tk_sched_pkg::*;
#(
  parameter int MISS_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               spawn_req,
  output logic               spawn_ack,
  output logic [TRD_W-1:0]   spawn_id,
  input  logic               kill,
  input  logic               sleep,
  input  logic               wake,
  input  logic [TRD_W-1:0]   obj_trd,
  input  logic               i_miss,
  input  logic               d_miss,
  input  logic [TRD_W-1:0]   d_miss_trd,
  output logic [TRD_W-1:0]   trd_if,
  output logic               trd_if_vld,
  output logic [NUM_TRD-1:0] valid_trd,
  output logic [NUM_TRD-1:0] run_trd,
  output logic               running,
  output logic               trd_full,
  output logic               trd_of
);

  logic [NUM_TRD-1:0] free_trd;
  logic [NUM_TRD-1:0] elig;
  logic [TRD_W-1:0]   ptr;
  logic [TRD_W-1:0]   pick;
  logic               pick_vld;

  assign valid_trd = ~free_trd;
  assign running   = |valid_trd;
  assign trd_full  = ~|free_trd;
  assign spawn_ack = spawn_req & ~trd_full;
  assign spawn_id  = lowest_set(free_trd);

  for (genvar i = 0; i < NUM_TRD; i++) begin : g_trd
    localparam logic [TRD_W-1:0] ID     = TRD_W'(i);
    localparam trd_state_t       RST_ST = (i == 0) ? RUN : FREE;

    trd_state_t st, st_nxt;
    logic [3:0] cnt, cnt_nxt;

    // Priority chain: kill > sleep > miss > wake; spawn only ever targets a FREE thread.
    always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      if (kill && obj_trd == ID && st != FREE) begin
        st_nxt  = FREE;
        cnt_nxt = '0;
      end else if (sleep && obj_trd == ID && (st == RUN || st == WAIT)) begin
        st_nxt  = SLEEP;
        cnt_nxt = '0;
      end else if (st == RUN && ((d_miss && d_miss_trd == ID) ||
                                 (i_miss && trd_if_vld && trd_if == ID))) begin
        st_nxt  = WAIT;
        cnt_nxt = 4'(MISS_LAT);
      end else if (st == SLEEP && wake && obj_trd == ID) begin
        st_nxt  = RUN;
      end else if (st == WAIT) begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) st_nxt = RUN;
      end else if (st == FREE && spawn_ack && spawn_id == ID) begin
        st_nxt  = RUN;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st  <= RST_ST;
        cnt <= '0;
      end else begin
        st  <= st_nxt;
        cnt <= cnt_nxt;
      end
    end

    assign free_trd[i] = (st == FREE);
    assign run_trd[i]  = (st == RUN);
    assign elig[i]     = (st_nxt == RUN);
  end

  rr_pick u_rr_pick (
    .req     (elig),
    .ptr     (ptr),
    .gnt_id  (pick),
    .gnt_vld (pick_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trd_if     <= '0;
      trd_if_vld <= 1'b0;
      ptr        <= TRD_W'(NUM_TRD - 1);
      trd_of     <= 1'b0;
    end else begin
      trd_of <= spawn_req & trd_full;
      if (stall) begin
        // A held thread that leaves RUN must not be presented to fetch as valid.
        if (!elig[trd_if]) trd_if_vld <= 1'b0;
      end else if (pick_vld) begin
        trd_if     <= pick;
        trd_if_vld <= 1'b1;
        ptr        <= pick;
      end else begin
        trd_if_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trd_sched.sv
// Directed bench for trd_sched: per-cycle vector table plus hand sequences for reset corners.
module tb_trd_sched;

  localparam int OP_NONE  = 0;
  localparam int OP_SPAWN = 1;
  localparam int OP_KILL  = 2;
  localparam int OP_SLEEP = 3;
  localparam int OP_WAKE  = 4;
  localparam int OP_IMISS = 5;
  localparam int OP_KDM   = 6;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       spawn_req;
  logic       spawn_ack;
  logic [2:0] spawn_id;
  logic       kill;
  logic       sleep;
  logic       wake;
  logic [2:0] obj_trd;
  logic       i_miss;
  logic       d_miss;
  logic [2:0] d_miss_trd;
  logic [2:0] trd_if;
  logic       trd_if_vld;
  logic [7:0] valid_trd;
  logic [7:0] run_trd;
  logic       running;
  logic       trd_full;
  logic       trd_of;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         op;
    logic [2:0] obj;
    logic       stall;
    logic [7:0] e_valid;
    logic [7:0] e_run;
    logic       e_ack;
    logic [2:0] e_id;
    logic [2:0] e_if;
    logic       e_vld;
    logic       e_of;
  } vec_t;

  vec_t tbl[$];

  trd_sched #(.MISS_LAT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .spawn_req  (spawn_req),
    .spawn_ack  (spawn_ack),
    .spawn_id   (spawn_id),
    .kill       (kill),
    .sleep      (sleep),
    .wake       (wake),
    .obj_trd    (obj_trd),
    .i_miss     (i_miss),
    .d_miss     (d_miss),
    .d_miss_trd (d_miss_trd),
    .trd_if     (trd_if),
    .trd_if_vld (trd_if_vld),
    .valid_trd  (valid_trd),
    .run_trd    (run_trd),
    .running    (running),
    .trd_full   (trd_full),
    .trd_of     (trd_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input int op, input int obj, input bit stl,
                             input logic [7:0] valid, input logic [7:0] run,
                             input bit ack, input int id, input int tif,
                             input bit vld, input bit of);
    vec_t t;
    t.op = op;       t.obj = 3'(obj);    t.stall = stl;
    t.e_valid = valid; t.e_run = run;    t.e_ack = ack;
    t.e_id = 3'(id); t.e_if = 3'(tif);   t.e_vld = vld;  t.e_of = of;
    return t;
  endfunction

  task automatic apply(input int op, input logic [2:0] obj, input logic stl);
    spawn_req  = (op == OP_SPAWN);
    kill       = (op == OP_KILL) || (op == OP_KDM);
    sleep      = (op == OP_SLEEP);
    wake       = (op == OP_WAKE);
    i_miss     = (op == OP_IMISS);
    d_miss     = (op == OP_KDM);
    obj_trd    = obj;
    d_miss_trd = obj;
    stall      = stl;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, got, exp);
    end
  endtask

  initial begin
    // op, obj, stall, valid, run, ack, id, trd_if, vld, of
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'h01, 8'h01, 1, 1, 0, 1, 0));
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'h03, 8'h03, 1, 2, 1, 1, 0));
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'h07, 8'h07, 1, 3, 2, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0F, 0, 0, 3, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0F, 0, 0, 0, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0F, 0, 0, 1, 1, 0));
    tbl.push_back(v(OP_IMISS, 0, 0, 8'h0F, 8'h0F, 0, 0, 2, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0B, 0, 0, 3, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0B, 0, 0, 0, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0B, 0, 0, 1, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0B, 0, 0, 3, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0F, 0, 0, 0, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0F, 0, 0, 1, 1, 0));
    tbl.push_back(v(OP_SLEEP, 1, 0, 8'h0F, 8'h0F, 0, 0, 2, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0D, 0, 0, 3, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0D, 0, 0, 0, 1, 0));
    tbl.push_back(v(OP_WAKE,  1, 0, 8'h0F, 8'h0D, 0, 0, 2, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0F, 0, 0, 3, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'h0F, 8'h0F, 0, 0, 0, 1, 0));
    tbl.push_back(v(OP_KILL,  3, 0, 8'h0F, 8'h0F, 0, 0, 1, 1, 0));
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'h07, 8'h07, 1, 3, 2, 1, 0));
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'h0F, 8'h0F, 1, 4, 3, 1, 0));
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'h1F, 8'h1F, 1, 5, 4, 1, 0));
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'h3F, 8'h3F, 1, 6, 5, 1, 0));
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'h7F, 8'h7F, 1, 7, 6, 1, 0));
    tbl.push_back(v(OP_SPAWN, 0, 0, 8'hFF, 8'hFF, 0, 0, 7, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'hFF, 8'hFF, 0, 0, 0, 1, 1));
    tbl.push_back(v(OP_KDM,   2, 0, 8'hFF, 8'hFF, 0, 0, 1, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'hFB, 8'hFB, 0, 0, 3, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 1, 8'hFB, 8'hFB, 0, 0, 4, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 1, 8'hFB, 8'hFB, 0, 0, 4, 1, 0));
    tbl.push_back(v(OP_SLEEP, 4, 1, 8'hFB, 8'hFB, 0, 0, 4, 1, 0));
    tbl.push_back(v(OP_NONE,  0, 1, 8'hFB, 8'hEB, 0, 0, 4, 0, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'hFB, 8'hEB, 0, 0, 4, 0, 0));
    tbl.push_back(v(OP_NONE,  0, 0, 8'hFB, 8'hEB, 0, 0, 5, 1, 0));

    rst = 1'b1;
    apply(OP_NONE, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid", -1, 32'(valid_trd), 32'h01);
    chk("rst_run",   -1, 32'(run_trd),   32'h01);
    chk("rst_vld",   -1, 32'(trd_if_vld), 32'h0);
    chk("rst_if",    -1, 32'(trd_if),    32'h0);
    chk("rst_of",    -1, 32'(trd_of),    32'h0);
    chk("rst_full",  -1, 32'(trd_full),  32'h0);
    rst = 1'b0;

    foreach (tbl[r]) begin
      @(negedge clk);
      apply(tbl[r].op, tbl[r].obj, tbl[r].stall);
      #1;
      chk("valid_trd",  r, 32'(valid_trd),  32'(tbl[r].e_valid));
      chk("run_trd",    r, 32'(run_trd),    32'(tbl[r].e_run));
      chk("trd_full",   r, 32'(trd_full),   32'(tbl[r].e_valid == 8'hFF));
      chk("running",    r, 32'(running),    32'(tbl[r].e_valid != 8'h00));
      chk("spawn_ack",  r, 32'(spawn_ack),  32'(tbl[r].e_ack));
      if (tbl[r].e_ack) chk("spawn_id", r, 32'(spawn_id), 32'(tbl[r].e_id));
      chk("trd_if",     r, 32'(trd_if),     32'(tbl[r].e_if));
      chk("trd_if_vld", r, 32'(trd_if_vld), 32'(tbl[r].e_vld));
      chk("trd_of",     r, 32'(trd_of),     32'(tbl[r].e_of));
    end

    // Park thread 0 in WAIT, then hit reset between clock edges.
    @(negedge clk);
    apply(OP_NONE, 3'd0, 1'b0);
    d_miss = 1'b1;
    d_miss_trd = 3'd0;
    @(posedge clk);
    #1;
    d_miss = 1'b0;
    chk("pre_rst_run", 100, 32'(run_trd), 32'hEA);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 101, 32'(valid_trd),  32'h01);
    chk("arst_run",   101, 32'(run_trd),    32'h01);
    chk("arst_if",    101, 32'(trd_if),     32'h0);
    chk("arst_vld",   101, 32'(trd_if_vld), 32'h0);
    chk("arst_of",    101, 32'(trd_of),     32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_if",  102, 32'(trd_if),     32'h0);
    chk("post_rst_vld", 102, 32'(trd_if_vld), 32'h1);
    repeat (5) @(negedge clk);
    #1;
    chk("post_rst_run", 103, 32'(run_trd),    32'h01);
    chk("post_rst_vld", 103, 32'(trd_if_vld), 32'h1);
    chk("post_rst_if",  103, 32'(trd_if),     32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trd_sched.md
Name: trd_sched

Overview:
- Barrel-thread scheduler for the ThreadKraken fetch stage.
- Tracks the lifecycle state of each of the 8 hardware threads and allocates thread IDs on spawn.
- Applies kill/sleep/wake and I/D-miss back-off to those states.
- Each cycle, picks one runnable thread round-robin to issue to instruction fetch.
- Sits between the writeback-stage thread-op decode, the MMU miss signals and the fetch PC mux.

Parameters:
- NUM_TRD, 8, number of hardware threads (power of 2).
- TRD_W, 3, thread ID width, equal to log2(NUM_TRD).
- MISS_LAT, 4, cycles a thread stays blocked after an I- or D-miss (range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  pipeline stall; holds the current issue selection.
- spawn_req  in  1  request to allocate a new thread.
- spawn_ack  out  1  allocation granted this cycle (combinational).
- spawn_id  out  TRD_W  ID allocated; valid when spawn_ack=1.
- kill  in  1  kill obj_trd.
- sleep  in  1  put obj_trd to sleep.
- wake  in  1  wake obj_trd.
- obj_trd  in  TRD_W  target thread of kill/sleep/wake.
- i_miss  in  1  I-fetch miss for the currently issued thread (trd_if).
- d_miss  in  1  D-side miss.
- d_miss_trd  in  TRD_W  thread that took the D-miss.
- trd_if  out  TRD_W  thread selected for fetch (registered).
- trd_if_vld  out  1  trd_if is valid (registered).
- valid_trd  out  NUM_TRD  per-thread: state is not FREE.
- run_trd  out  NUM_TRD  per-thread: state is RUN.
- running  out  1  OR of valid_trd.
- trd_full  out  1  no thread is FREE.
- trd_of  out  1  one-cycle pulse, registered, on spawn_req while full.

Behaviour:
- Per-thread FSM states: FREE, RUN, SLEEP, WAIT. Each thread has a 4-bit miss counter.
- Reset values:
  - thread 0 is RUN; all other threads FREE; all counters 0.
  - round-robin pointer = NUM_TRD-1, so thread 0 is picked first.
  - trd_if=0, trd_if_vld=0, trd_of=0.
- Transitions, resolved per thread with priority kill > sleep > d_miss > i_miss > wake:
  - kill: any non-FREE state -> FREE; counter cleared. Kill of a FREE thread is ignored.
  - sleep: RUN or WAIT -> SLEEP; counter cleared.
  - d_miss / i_miss: RUN -> WAIT; counter loaded with MISS_LAT. A miss on a non-RUN thread is ignored. i_miss applies to trd_if only when trd_if_vld=1.
  - WAIT: counter decrements each cycle; when it reaches 1, next state is RUN. A thread is therefore blocked for exactly MISS_LAT cycles.
  - wake: SLEEP -> RUN. Ignored in any other state.
  - spawn: the lowest-index FREE thread -> RUN next cycle.
    - spawn_ack = spawn_req & ~trd_full; spawn_id = lowest FREE index.
    - Spawn is evaluated against the current-cycle state. A thread freed by kill in the same cycle is not reusable until the next cycle.
- Issue selection:
  - Eligible mask = threads whose next state is RUN, so a thread that missed this cycle is not re-issued.
  - Pick the first eligible index strictly after the pointer, wrapping modulo NUM_TRD.
  - On a pick: trd_if <= pick, trd_if_vld <= 1, pointer <= pick.
  - With no eligible thread: trd_if_vld <= 0; trd_if and pointer hold.
- stall=1:
  - trd_if, trd_if_vld and pointer hold.
  - FSM updates (kill/sleep/wake/miss/spawn) and counter decrements still proceed.
  - If the held thread leaves RUN, trd_if_vld drops to 0 on the next cycle, even under stall.
- valid_trd, run_trd, trd_full, running: combinational from current state.
- trd_of: registered pulse; one cycle per cycle in which spawn_req=1 and trd_full=1.
- Reset asserted mid-operation returns everything to the reset state immediately (asynchronous). No pending miss counter survives reset.

Decomposition:
- Package tk_sched_pkg holds:
  - trd_state_t enum {FREE, RUN, SLEEP, WAIT}, 2 bits.
  - NUM_TRD and TRD_W localparams.
  - Function lowest_set(), used for spawn_id.
- Sub-module rr_pick: round-robin picker.
  - Inputs: req[NUM_TRD], ptr[TRD_W].
  - Outputs: gnt_id[TRD_W], gnt_vld.
  - Purely combinational, using a double-width mask trick.
- Top level holds the per-thread FSM and counters via generate, plus the output registers.

Test Plan:
- Reset: release rst -> trd_if_vld=1, trd_if=0 on the first edge; valid_trd=8'h01, running=1, trd_full=0.
- Spawn and rotation: 3 spawn_req pulses -> spawn_id 1, 2, 3 with spawn_ack=1. Thereafter trd_if cycles 0,1,2,3,0,1 on consecutive cycles.
- Miss back-off (MISS_LAT=4), threads 0..3 running: i_miss while trd_if=2 -> run_trd bit 2 is clear for 4 cycles and thread 2 is skipped. It is issued again after run_trd[2] returns to 1.
- Sleep/wake/kill: sleep obj_trd=1 -> run_trd=8'h0D, valid_trd=8'h0F. wake obj_trd=1 -> thread 1 rejoins rotation. kill obj_trd=3 -> valid_trd=8'h07; the next spawn returns spawn_id=3.
- Full and overflow: spawn until valid_trd=8'hFF -> trd_full=1. One more spawn_req -> spawn_ack=0 and trd_of is high for exactly 1 cycle.
- Collisions and stall:
  - Same cycle kill and d_miss on thread 2 -> thread 2 FREE, no WAIT.
  - stall=1 for 3 cycles -> trd_if is constant.
  - sleep of the held thread during stall -> trd_if_vld=0 on the next cycle.
